// File: rtl/vector_pkg.sv
// Shared types for the vector memory path: lane/width defaults, vector
// containers and the sequencer state encoding.
package vector_pkg;

  localparam int LANES_DEF  = 4;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  typedef logic [DATA_W_DEF-1:0] vector_t [LANES_DEF];
  typedef logic [ADDR_W_DEF-1:0] vaddr_t  [LANES_DEF];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/vector_mem_sequencer.sv
// Serialises a latched vector load/store onto a single-port data memory,
// one lane per cycle, gathering load returns into loadVector.
module vector_mem_sequencer
  import vector_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              isStore,
  input  logic [ADDR_W-1:0] addressVector [LANES],
  input  logic [DATA_W-1:0] storeVector   [LANES],
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWriteData,
  output logic              memWe,
  output logic              memRe,
  input  logic [DATA_W-1:0] memReadData,
  output logic [DATA_W-1:0] loadVector    [LANES],
  output logic              busy,
  output logic              done
);

  localparam int              CW   = $clog2(LANES) + 1;
  localparam int              IW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0]   LAST = CW'(LANES - 1);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  seq_state_t        stateR, nextStateS;
  logic [CW-1:0]     laneR, nextLaneS, capLaneS;
  logic [IW-1:0]     nextIdxS, capIdxS;
  logic              isStoreR, selStoreS;
  logic [ADDR_W-1:0] addrR [LANES];
  logic [DATA_W-1:0] dataR [LANES];
  logic [ADDR_W-1:0] memAddrS;
  logic [DATA_W-1:0] memWriteDataS;
  logic              memWeS, memReS, busyS, doneS;

  // State and lane counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR <= IDLE;
      laneR  <= '0;
    end else begin
      stateR <= nextStateS;
      laneR  <= nextLaneS;
    end
  end

  // Next-state and lane counter logic
  always_comb begin
    nextStateS = stateR;
    nextLaneS  = laneR;
    case (stateR)
      IDLE: begin
        if (start) begin
          nextStateS = ISSUE;
          nextLaneS  = '0;
        end else begin
          nextStateS = IDLE;
        end
      end
      ISSUE: begin
        nextLaneS = laneR + ONE;
        if (laneR == LAST) begin
          nextStateS = isStoreR ? DONE : DRAIN;
        end else begin
          nextStateS = ISSUE;
        end
      end
      DRAIN:   nextStateS = DONE;
      DONE:    nextStateS = IDLE;
      default: nextStateS = IDLE;
    endcase
  end

  // Operand capture on acceptance; later input changes cannot disturb the op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isStoreR <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        addrR[i] <= '0;
        dataR[i] <= '0;
      end
    end else if (stateR == IDLE && start) begin
      isStoreR <= isStore;
      addrR    <= addressVector;
      dataR    <= storeVector;
    end
  end

  // Outputs are registered, so decode from the upcoming state; on the
  // accepting edge the operands come straight from the inputs
  always_comb begin
    nextIdxS      = nextLaneS[IW-1:0];
    selStoreS     = (stateR == IDLE) ? isStore : isStoreR;
    memAddrS      = '0;
    memWriteDataS = '0;
    memWeS        = 1'b0;
    memReS        = 1'b0;
    busyS         = 1'b0;
    doneS         = 1'b0;
    case (nextStateS)
      ISSUE: begin
        busyS    = 1'b1;
        memAddrS = (stateR == IDLE) ? addressVector[nextIdxS] : addrR[nextIdxS];
        if (selStoreS) begin
          memWeS        = 1'b1;
          memWriteDataS = (stateR == IDLE) ? storeVector[nextIdxS] : dataR[nextIdxS];
        end else begin
          memReS = 1'b1;
        end
      end
      DRAIN:   busyS = 1'b1;
      DONE:    doneS = 1'b1;
      default: busyS = 1'b0;
    endcase
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memAddr      <= '0;
      memWriteData <= '0;
      memWe        <= 1'b0;
      memRe        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      memAddr      <= memAddrS;
      memWriteData <= memWriteDataS;
      memWe        <= memWeS;
      memRe        <= memReS;
      busy         <= busyS;
      done         <= doneS;
    end
  end

  // Read data lags its issue by one cycle, so the current lane count minus one names the returning lane
  always_comb begin
    capLaneS = laneR - ONE;
    capIdxS  = capLaneS[IW-1:0];
  end

  // Load gather register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        loadVector[i] <= '0;
      end
    end else if ((stateR == ISSUE && laneR != '0 && !isStoreR) || stateR == DRAIN) begin
      loadVector[capIdxS] <= memReadData;
    end
  end

endmodule
